// File: rtl/cr_intc_pkg.sv
// Shared types and constants for the core-timer interrupt controller.
package cr_intc_pkg;

  // Request handshake states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } intc_state_e;

  // Register block sits at addr[7:4] == 4'h2; addr[3:2] picks the register
  localparam logic [3:0] INTC_BASE_NIB = 4'h2;
  localparam logic [1:0] REG_IER       = 2'd0;
  localparam logic [1:0] REG_IPR       = 2'd1;
  localparam logic [1:0] REG_PRIO      = 2'd2;
  localparam logic [1:0] REG_ACT       = 2'd3;

  // Largest source count the 4-bit ID can address
  localparam int MAX_SRC = 16;

endpackage

// File: rtl/cr_intc_arb.sv
// Combinational arbiter: highest priority value wins, lowest index breaks ties.
module cr_intc_arb
  import cr_intc_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 2
) (
  input  logic [NUM_SRC-1:0]        cand,
  input  logic [NUM_SRC*PRIO_W-1:0] prio,
  output logic [3:0]                win_id,
  output logic                      any_vld
);

  logic [PRIO_W-1:0] best_prio_s;
  logic [3:0]        best_id_s;
  logic              found_s;

  // Scan upward from index 0; strict greater-than keeps the lower index on ties
  always_comb begin
    best_prio_s = {PRIO_W{1'b0}};
    best_id_s   = 4'h0;
    found_s     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && (!found_s || (prio[i*PRIO_W +: PRIO_W] > best_prio_s))) begin
        best_prio_s = prio[i*PRIO_W +: PRIO_W];
        best_id_s   = 4'(i);
        found_s     = 1'b1;
      end else begin
        found_s     = found_s;
      end
    end
  end

  assign win_id  = best_id_s;
  assign any_vld = found_s;

endmodule

// File: rtl/cr_tim_intc.sv
// Vectored interrupt controller behind the core timer: source 0 is the timer
// level, sources 1..NUM_SRC-1 are asynchronous rising-edge pads.
module cr_tim_intc
  import cr_intc_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 2
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               ctim_pad_int_vld,
  input  logic [NUM_SRC-2:0] pad_intc_src,
  input  logic               tcipif_intc_sel,
  input  logic [15:0]        tcipif_intc_addr,
  input  logic               tcipif_intc_write,
  input  logic [31:0]        tcipif_intc_wdata,
  output logic               intc_tcipif_cmplt,
  output logic [31:0]        intc_tcipif_rdata,
  output logic               intc_core_int_vld,
  output logic [3:0]         intc_core_int_id,
  input  logic               core_intc_int_ack
);

  logic [NUM_SRC-1:0]        ier_r;
  logic [NUM_SRC*PRIO_W-1:0] prio_r;
  logic [NUM_SRC-1:1]        edge_pend_r;
  logic [NUM_SRC-2:0]        sync1_r, sync2_r, sync3_r;
  intc_state_e               state_r;
  logic [3:0]                req_id_r, active_id_r;
  logic                      vld_r;

  logic                      hit_s, wr_hit_s, rd_hit_s, eoi_s;
  logic [NUM_SRC-1:0]        pend_s, cand_s, req_sel_s;
  logic [NUM_SRC-1:1]        rise_s, w1c_s, ack_clr_s;
  logic [3:0]                win_id_s;
  logic                      any_s, req_cand_s;
  logic [31:0]               rdata_s;
  logic                      unused_s;

  assign hit_s    = tcipif_intc_sel && (tcipif_intc_addr[7:4] == INTC_BASE_NIB);
  assign wr_hit_s = hit_s && tcipif_intc_write;
  assign rd_hit_s = hit_s && !tcipif_intc_write;
  assign eoi_s    = wr_hit_s && (tcipif_intc_addr[3:2] == REG_ACT) && (state_r == ST_ACTIVE);
  assign rise_s   = sync2_r & ~sync3_r;
  assign pend_s   = {edge_pend_r, ctim_pad_int_vld};
  assign cand_s   = ier_r & pend_s;
  assign unused_s = ^{tcipif_intc_addr[15:8], tcipif_intc_addr[1:0], tcipif_intc_wdata};

  cr_intc_arb #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) u_arb (
    .cand    (cand_s),
    .prio    (prio_r),
    .win_id  (win_id_s),
    .any_vld (any_s)
  );

  // One-hot of the held request ID, used for withdrawal check and ack clear
  always_comb begin
    req_sel_s = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      req_sel_s[i] = (req_id_r == 4'(i));
    end
  end

  assign req_cand_s = |(cand_s & req_sel_s);

  // Pending-bit clear masks from software W1C and from the core's ack
  always_comb begin
    if (wr_hit_s && (tcipif_intc_addr[3:2] == REG_IPR)) begin
      w1c_s = tcipif_intc_wdata[NUM_SRC-1:1];
    end else begin
      w1c_s = {(NUM_SRC-1){1'b0}};
    end
    if ((state_r == ST_REQ) && core_intc_int_ack) begin
      ack_clr_s = req_sel_s[NUM_SRC-1:1];
    end else begin
      ack_clr_s = {(NUM_SRC-1){1'b0}};
    end
  end

  // Pad synchronizers plus delay stage for rising-edge detection
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      sync1_r <= {(NUM_SRC-1){1'b0}};
      sync2_r <= {(NUM_SRC-1){1'b0}};
      sync3_r <= {(NUM_SRC-1){1'b0}};
    end else begin
      sync1_r <= pad_intc_src;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Software-visible enable, priority and edge-pending state; new edges beat clears
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ier_r       <= {NUM_SRC{1'b0}};
      prio_r      <= {(NUM_SRC*PRIO_W){1'b0}};
      edge_pend_r <= {(NUM_SRC-1){1'b0}};
    end else begin
      if (wr_hit_s && (tcipif_intc_addr[3:2] == REG_IER)) begin
        ier_r <= tcipif_intc_wdata[NUM_SRC-1:0];
      end
      if (wr_hit_s && (tcipif_intc_addr[3:2] == REG_PRIO)) begin
        prio_r <= tcipif_intc_wdata[NUM_SRC*PRIO_W-1:0];
      end
      edge_pend_r <= (edge_pend_r & ~w1c_s & ~ack_clr_s) | rise_s;
    end
  end

  // Request handshake: latch winner, hold until ack or withdrawal, wait for EOI
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_r     <= ST_IDLE;
      req_id_r    <= 4'h0;
      active_id_r <= 4'h0;
      vld_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            state_r  <= ST_REQ;
            req_id_r <= win_id_s;
            vld_r    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (core_intc_int_ack) begin
            state_r     <= ST_ACTIVE;
            active_id_r <= req_id_r;
            vld_r       <= 1'b0;
          end else if (!req_cand_s) begin
            state_r <= ST_IDLE;
            vld_r   <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (eoi_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          vld_r   <= 1'b0;
        end
      endcase
    end
  end

  // Combinational register read mux; zero when no read is decoded
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (rd_hit_s) begin
      case (tcipif_intc_addr[3:2])
        REG_IER:  rdata_s[NUM_SRC-1:0] = ier_r;
        REG_IPR:  rdata_s[NUM_SRC-1:0] = pend_s;
        REG_PRIO: rdata_s[NUM_SRC*PRIO_W-1:0] = prio_r;
        REG_ACT: begin
          rdata_s[31]  = (state_r == ST_ACTIVE);
          rdata_s[3:0] = active_id_r;
        end
        default:  rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign intc_tcipif_rdata = rdata_s;
  assign intc_tcipif_cmplt = tcipif_intc_sel;
  assign intc_core_int_vld = vld_r;
  assign intc_core_int_id  = req_id_r;

endmodule

// File: tb/tb_cr_tim_intc.sv
// Directed bench for cr_tim_intc with hand-computed expectations.
module tb_cr_tim_intc;

  localparam int NUM_SRC = 8;
  localparam int PRIO_W  = 2;
  localparam logic [15:0] A_IER  = 16'h0020;
  localparam logic [15:0] A_IPR  = 16'h0024;
  localparam logic [15:0] A_PRIO = 16'h0028;
  localparam logic [15:0] A_ACT  = 16'h002C;

  logic               clk = 1'b0;
  logic               rst;
  logic               ctim;
  logic [NUM_SRC-2:0] pad;
  logic               sel;
  logic [15:0]        addr;
  logic               write;
  logic [31:0]        wdata;
  logic               cmplt;
  logic [31:0]        rdata;
  logic               vld;
  logic [3:0]         id;
  logic               ack;
  logic [31:0]        rd_val;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #10 clk = ~clk;

  cr_tim_intc #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
    .forever_cpuclk    (clk),
    .cpurst            (rst),
    .ctim_pad_int_vld  (ctim),
    .pad_intc_src      (pad),
    .tcipif_intc_sel   (sel),
    .tcipif_intc_addr  (addr),
    .tcipif_intc_write (write),
    .tcipif_intc_wdata (wdata),
    .intc_tcipif_cmplt (cmplt),
    .intc_tcipif_rdata (rdata),
    .intc_core_int_vld (vld),
    .intc_core_int_id  (id),
    .core_intc_int_ack (ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [31:0] d);
    sel = 1'b1; write = 1'b1; addr = a; wdata = d;
    tick(1);
    sel = 1'b0; write = 1'b0; addr = 16'h0000; wdata = 32'h0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    sel = 1'b1; write = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd_chk(input logic [15:0] a, input string tag, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check_val(tag, d, exp);
  endtask

  task automatic chk_req(input string tag, input logic ev, input logic [3:0] eid);
    check_val({tag, "_vld"}, {31'h0, vld}, {31'h0, ev});
    if (ev) check_val({tag, "_id"}, {28'h0, id}, {28'h0, eid});
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctim = 1'b0; pad = '0; sel = 1'b0; addr = 16'h0; write = 1'b0;
    wdata = 32'h0; ack = 1'b0;
    tick(2);
    check_val("rst_vld", {31'h0, vld}, 32'h0);
    check_val("rst_id", {28'h0, id}, 32'h0);
    rst = 1'b0;
    rd_chk(A_IER, "rst_ier", 32'h0);
    rd_chk(A_IPR, "rst_ipr", 32'h0);
    rd_chk(A_PRIO, "rst_prio", 32'h0);
    rd_chk(A_ACT, "rst_act", 32'h0);
    sel = 1'b1; addr = A_IER; #1;
    check_val("cmplt_sel", {31'h0, cmplt}, 32'h1);
    sel = 1'b0; #1;
    check_val("cmplt_nosel", {31'h0, cmplt}, 32'h0);

    // Timer path
    reg_wr(A_IER, 32'h01);
    check_val("nosel_rdata", rdata, 32'h0);
    ctim = 1'b1;
    tick(1);
    chk_req("tim_req", 1'b1, 4'd0);
    rd_chk(A_ACT, "tim_act_req", 32'h0);
    rd_chk(16'h0030, "undecoded", 32'h0);
    do_ack();
    chk_req("tim_ack", 1'b0, 4'd0);
    rd_chk(A_ACT, "tim_act", 32'h8000_0000);
    rd_chk(A_IPR, "tim_ipr", 32'h01);
    ctim = 1'b0;
    reg_wr(A_ACT, 32'h0);
    tick(2);
    chk_req("tim_eoi", 1'b0, 4'd0);
    rd_chk(A_ACT, "tim_act_eoi", 32'h0);

    // Edge source 2 on pad bit 1
    reg_wr(A_IER, 32'h04);
    pad = 7'b0000010;
    tick(2);
    pad = '0;
    chk_req("edge_n1", 1'b0, 4'd0);
    tick(1);
    rd_chk(A_IPR, "edge_ipr", 32'h04);
    chk_req("edge_n2", 1'b0, 4'd0);
    tick(1);
    chk_req("edge_req", 1'b1, 4'd2);
    do_ack();
    chk_req("edge_ack", 1'b0, 4'd0);
    rd_chk(A_IPR, "edge_ipr_clr", 32'h0);
    rd_chk(A_ACT, "edge_act", 32'h8000_0002);
    pad = 7'b0000010;
    tick(2);
    pad = '0;
    tick(2);
    rd_chk(A_IPR, "edge_ipr_held", 32'h04);
    chk_req("edge_held", 1'b0, 4'd0);
    reg_wr(A_ACT, 32'h0);
    chk_req("edge_idle_gap", 1'b0, 4'd0);
    tick(1);
    chk_req("edge_req2", 1'b1, 4'd2);
    do_ack();
    rd_chk(A_IPR, "edge_ipr_clr2", 32'h0);
    reg_wr(A_ACT, 32'h0);
    tick(1);
    chk_req("edge_done", 1'b0, 4'd0);
    reg_wr(A_IER, 32'h0);

    // Priority and tie-break between sources 1 and 3
    pad = 7'b0000101;
    tick(2);
    pad = '0;
    tick(2);
    rd_chk(A_IPR, "pri_ipr", 32'h0A);
    reg_wr(A_PRIO, 32'h44);
    reg_wr(A_IER, 32'h0A);
    tick(1);
    chk_req("pri_tie", 1'b1, 4'd1);
    do_ack();
    rd_chk(A_IPR, "pri_ipr_ack", 32'h08);
    rd_chk(A_ACT, "pri_act", 32'h8000_0001);
    pad = 7'b0000001;
    tick(2);
    pad = '0;
    tick(2);
    rd_chk(A_IPR, "pri_ipr_both", 32'h0A);
    reg_wr(A_PRIO, 32'hC4);
    rd_chk(A_PRIO, "pri_prio", 32'hC4);
    reg_wr(A_ACT, 32'h0);
    tick(1);
    chk_req("pri_high", 1'b1, 4'd3);
    do_ack();
    reg_wr(A_ACT, 32'h0);
    tick(1);
    chk_req("pri_low", 1'b1, 4'd1);
    do_ack();
    reg_wr(A_ACT, 32'h0);
    rd_chk(A_IPR, "pri_ipr_end", 32'h0);
    reg_wr(A_IER, 32'h0);

    // Withdrawal of a timer request, then ack racing the drop
    reg_wr(A_PRIO, 32'h0);
    reg_wr(A_IER, 32'h01);
    ctim = 1'b1;
    tick(1);
    chk_req("wd_req", 1'b1, 4'd0);
    ctim = 1'b0;
    tick(1);
    chk_req("wd_drop", 1'b0, 4'd0);
    tick(1);
    chk_req("wd_idle", 1'b0, 4'd0);
    rd(A_ACT, rd_val);
    check_val("wd_act_vld", rd_val & 32'h8000_0000, 32'h0);
    ctim = 1'b1;
    tick(1);
    chk_req("race_req", 1'b1, 4'd0);
    ctim = 1'b0;
    do_ack();
    chk_req("race_ack", 1'b0, 4'd0);
    rd_chk(A_ACT, "race_act", 32'h8000_0000);
    reg_wr(A_ACT, 32'h0);
    tick(1);
    chk_req("race_eoi", 1'b0, 4'd0);

    // W1C racing a new edge on source 5 (pad bit 4)
    reg_wr(A_IER, 32'h0);
    pad = 7'b0010000;
    tick(2);
    pad = '0;
    tick(3);
    rd_chk(A_IPR, "w1c_pend", 32'h20);
    pad = 7'b0010000;
    tick(2);
    pad = '0;
    reg_wr(A_IPR, 32'h20);
    rd_chk(A_IPR, "w1c_set_wins", 32'h20);
    reg_wr(A_IPR, 32'h20);
    rd_chk(A_IPR, "w1c_clear", 32'h0);
    ctim = 1'b1;
    rd_chk(A_IPR, "w1c_b0_pre", 32'h01);
    reg_wr(A_IPR, 32'h01);
    rd_chk(A_IPR, "w1c_b0_ro", 32'h01);
    ctim = 1'b0;

    // EOI in IDLE is ignored; controller still requests afterwards
    reg_wr(A_ACT, 32'h0);
    chk_req("eoi_idle", 1'b0, 4'd0);
    rd(A_ACT, rd_val);
    check_val("eoi_idle_act", rd_val & 32'h8000_0000, 32'h0);
    reg_wr(A_IER, 32'h01);
    ctim = 1'b1;
    tick(1);
    chk_req("eoi_idle_req", 1'b1, 4'd0);
    do_ack();
    rd_chk(A_ACT, "pre_rst_act", 32'h8000_0000);

    // Reset while ACTIVE with state loaded everywhere
    reg_wr(A_PRIO, 32'hFF);
    reg_wr(A_IER, 32'hFF);
    pad = 7'b0010000;
    tick(2);
    pad = '0;
    tick(2);
    rd_chk(A_IPR, "pre_rst_ipr", 32'h21);
    ctim = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_req("mid_rst", 1'b0, 4'd0);
    rd_chk(A_IER, "mid_rst_ier", 32'h0);
    rd_chk(A_IPR, "mid_rst_ipr", 32'h0);
    rd_chk(A_PRIO, "mid_rst_prio", 32'h0);
    rd_chk(A_ACT, "mid_rst_act", 32'h0);
    reg_wr(A_IER, 32'h01);
    ctim = 1'b1;
    tick(1);
    chk_req("post_rst_req", 1'b1, 4'd0);
    do_ack();
    ctim = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
